ball_motion: RTL

Ball position integrator for the 160x120 Pong playfield, sitting between the ball-physics trajectory table and the renderer/scorer. It consumes signed velocity vectors (pixels per second per axis) and advances the ball one pixel at a time using per-axis accumulators. It handles wall bounces itself, detects paddle contacts and reports the hit section (0-9) back to ball physics, stalling until a new vector is returned. Ball exits past either edge are reported as a miss.

---
 rtl/ball_motion.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ball_motion.sv
// ball_motion: Pong ball integrator with per-axis step accumulators, wall bounce, paddle hit and miss reporting.
// Define BALL_MOTION_HIT_TIMEOUT_EN to self-reflect after 16 unanswered step_ticks in HIT_WAIT.
module ball_motion #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PADDLE_W = 3,
    parameter int PADDLE_H = 20,
    parameter int STEP_DIV = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_tick,
    input  logic       serve,
    input  logic [7:0] vel_x,
    input  logic [7:0] vel_y,
    input  logic       vel_load,
    input  logic [6:0] left_paddle_y,
    input  logic [6:0] right_paddle_y,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       hit_valid,
    output logic       hit_side,
    output logic [3:0] hit_section,
    output logic       miss_left,
    output logic       miss_right,
    output logic       active
);
    typedef enum logic [1:0] {IDLE, MOVE, HIT_WAIT, OUT} state_t;

    localparam logic [7:0] CX    = 8'(SCREEN_W / 2);
    localparam logic [6:0] CY    = 7'(SCREEN_H / 2);
    localparam logic [7:0] X_L   = 8'(PADDLE_W);
    localparam logic [7:0] X_R   = 8'(SCREEN_W - PADDLE_W - 1);
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);
    localparam logic [7:0] PH    = 8'(PADDLE_H - 1);
    localparam logic [8:0] DIV   = 9'(STEP_DIV);

    state_t     r_state;
    logic [7:0] r_vx, r_vy, r_acc_x, r_acc_y, r_ball_x;
    logic [6:0] r_ball_y;
    logic       r_miss_l, r_miss_r, r_side;
    logic [3:0] r_sect;

    // -128 has no positive counterpart, so it is folded onto -127
    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'h80) ? 8'h81 : v;
    endfunction

    function automatic logic [6:0] mag(input logic [7:0] v);
        return v[7] ? 7'(8'd0 - sat(v)) : v[6:0];
    endfunction

    logic [8:0] w_sum_x, w_sum_y;
    logic       w_step_x, w_step_y, w_wall, w_in_pad, w_at_face, w_hit, w_exit;
    logic [7:0] w_acc_x_nx, w_acc_y_nx, w_x_nx;
    logic [6:0] w_y_nx, w_pad_y;
    logic [3:0] w_sect;

    assign w_sum_x    = {1'b0, r_acc_x} + {2'b0, mag(r_vx)};
    assign w_sum_y    = {1'b0, r_acc_y} + {2'b0, mag(r_vy)};
    assign w_step_x   = w_sum_x >= DIV;
    assign w_step_y   = w_sum_y >= DIV;
    assign w_acc_x_nx = w_step_x ? 8'(w_sum_x - DIV) : w_sum_x[7:0];
    assign w_acc_y_nx = w_step_y ? 8'(w_sum_y - DIV) : w_sum_y[7:0];
    assign w_wall     = w_step_y && (r_vy[7] ? (r_ball_y == 7'd0) : (r_ball_y == Y_MAX));
    assign w_y_nx     = (w_step_y && !w_wall) ? (r_vy[7] ? r_ball_y - 7'd1 : r_ball_y + 7'd1) : r_ball_y;
    assign w_pad_y    = r_vx[7] ? left_paddle_y : right_paddle_y;
    assign w_in_pad   = (r_ball_y >= w_pad_y) && ({1'b0, r_ball_y} <= {1'b0, w_pad_y} + PH);
    assign w_at_face  = r_vx[7] ? (r_ball_x == X_L) : (r_ball_x == X_R);
    assign w_hit      = w_step_x && w_at_face && w_in_pad;
    assign w_exit     = w_step_x && (r_vx[7] ? (r_ball_x == 8'd0) : (r_ball_x == X_MAX));
    assign w_x_nx     = (w_step_x && !w_hit && !w_exit) ? (r_vx[7] ? r_ball_x - 8'd1 : r_ball_x + 8'd1) : r_ball_x;
    assign w_sect     = 4'((r_ball_y - w_pad_y) >> 1);

`ifdef BALL_MOTION_HIT_TIMEOUT_EN
    logic [3:0] r_to_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_vx     <= '0;
            r_vy     <= '0;
            r_acc_x  <= '0;
            r_acc_y  <= '0;
            r_ball_x <= CX;
            r_ball_y <= CY;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            r_side   <= 1'b0;
            r_sect   <= '0;
`ifdef BALL_MOTION_HIT_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            unique case (r_state)
                IDLE: if (serve) begin
                    r_vx    <= sat(vel_x);
                    r_vy    <= sat(vel_y);
                    r_acc_x <= '0;
                    r_acc_y <= '0;
                    r_state <= MOVE;
                end
                MOVE: if (step_tick) begin
                    r_acc_x <= w_acc_x_nx;
                    r_acc_y <= w_acc_y_nx;
                    r_vy    <= w_wall ? 8'd0 - r_vy : r_vy;
                    if (w_hit) begin
                        r_state <= HIT_WAIT;
                        r_side  <= ~r_vx[7];
                        r_sect  <= w_sect;
`ifdef BALL_MOTION_HIT_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end else begin
                        r_ball_x <= w_x_nx;
                        r_ball_y <= w_y_nx;
                        if (w_exit) begin
                            r_state  <= OUT;
                            r_miss_l <= r_vx[7];
                            r_miss_r <= ~r_vx[7];
                        end
                    end
                end
                HIT_WAIT: if (vel_load) begin
                    r_vx    <= r_side ? 8'd0 - {1'b0, mag(vel_x)} : {1'b0, mag(vel_x)};
                    r_vy    <= sat(vel_y);
                    r_acc_x <= '0;
                    r_acc_y <= '0;
                    r_state <= MOVE;
                end
`ifdef BALL_MOTION_HIT_TIMEOUT_EN
                else if (step_tick) begin
                    r_to_cnt <= r_to_cnt + 4'd1;
                    if (r_to_cnt == 4'd15) begin
                        r_vx    <= 8'd0 - r_vx;
                        r_state <= MOVE;
                    end
                end
`endif
                OUT: begin
                    r_ball_x <= CX;
                    r_ball_y <= CY;
                    r_vx     <= '0;
                    r_vy     <= '0;
                    r_acc_x  <= '0;
                    r_acc_y  <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign hit_valid   = r_state == HIT_WAIT;
    assign hit_side    = r_side;
    assign hit_section = r_sect;
    assign miss_left   = r_miss_l;
    assign miss_right  = r_miss_r;
    assign active      = (r_state == MOVE) || (r_state == HIT_WAIT);
endmodule
